// File: rtl/l2_req_arbiter.sv
// Arbitrates the single L2 line-fill port between the icache, dcache and prefetcher.
// ic/dc share round-robin; pf is lowest priority, with a guard that forces a pf grant.
module l2_req_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 256,
  parameter int OFFSET_BITS     = 5,
  parameter int PF_STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic                  ic_request,
  output logic [LINE_WIDTH-1:0] ic_data,
  output logic                  ic_done,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic                  dc_request,
  output logic [LINE_WIDTH-1:0] dc_data,
  output logic                  dc_done,
  input  logic [ADDR_WIDTH-1:0] pf_addr,
  input  logic                  pf_request,
  output logic [LINE_WIDTH-1:0] pf_data,
  output logic                  pf_done,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic                  l2_request,
  input  logic [LINE_WIDTH-1:0] l2_data,
  input  logic                  l2_done,
  output logic                  busy,
  output logic [1:0]            grant_id
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_IC   = 2'd1;
  localparam logic [1:0] GID_DC   = 2'd2;
  localparam logic [1:0] GID_PF   = 2'd3;

  localparam int SW = (PF_STARVE_LIMIT < 1) ? 1 : $clog2(PF_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(PF_STARVE_LIMIT);

  logic [1:0]            state;
  logic                  rr_dc;
  logic [SW-1:0]         starve_cnt;
  logic                  pf_forced;
  logic                  ic_dc_tie;
  logic [1:0]            win;
  logic [ADDR_WIDTH-1:0] win_addr;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << OFFSET_BITS;
    return a & mask;
  endfunction

  // Winner selection, only acted on while IDLE
  always_comb begin
    pf_forced = pf_request && (starve_cnt == STARVE_MAX);
    ic_dc_tie = ic_request && dc_request;
    win       = GID_NONE;
    if (pf_forced)       win = GID_PF;
    else if (ic_dc_tie)  win = rr_dc ? GID_DC : GID_IC;
    else if (ic_request) win = GID_IC;
    else if (dc_request) win = GID_DC;
    else if (pf_request) win = GID_PF;
  end

  always_comb begin
    win_addr = '0;
    case (win)
      GID_IC:  win_addr = ic_addr;
      GID_DC:  win_addr = dc_addr;
      GID_PF:  win_addr = pf_addr;
      default: win_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_dc      <= 1'b0;
      starve_cnt <= '0;
      l2_addr    <= '0;
      l2_request <= 1'b0;
      grant_id   <= GID_NONE;
      busy       <= 1'b0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      pf_done    <= 1'b0;
      ic_data    <= '0;
      dc_data    <= '0;
      pf_data    <= '0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      pf_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win != GID_NONE) begin
            l2_addr    <= line_align(win_addr);
            l2_request <= 1'b1;
            grant_id   <= win;
            busy       <= 1'b1;
            state      <= ST_WAIT;
            // The pointer only moves when it actually broke an ic/dc tie
            if (ic_dc_tie && !pf_forced) rr_dc <= ~rr_dc;
          end
        end
        ST_WAIT: begin
          if (l2_done) begin
            l2_request <= 1'b0;
            state      <= ST_RESP;
            case (grant_id)
              GID_IC: begin
                ic_data <= l2_data;
                ic_done <= 1'b1;
              end
              GID_DC: begin
                dc_data <= l2_data;
                dc_done <= 1'b1;
              end
              GID_PF: begin
                pf_data <= l2_data;
                pf_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_RESP: begin
          grant_id <= GID_NONE;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Starvation guard counts ic/dc wins that happened while pf was waiting
      if (!pf_request) begin
        starve_cnt <= '0;
      end else if (state == ST_IDLE && win == GID_PF) begin
        starve_cnt <= '0;
      end else if (state == ST_IDLE && (win == GID_IC || win == GID_DC) &&
                   starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed scoreboard bench for l2_req_arbiter: expected grants are queued at
// stimulus time and checked as the DUT grants and completes each fill.
module tb_l2_req_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [1:0] ID_IC = 2'd1;
  localparam logic [1:0] ID_DC = 2'd2;
  localparam logic [1:0] ID_PF = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ic_addr, dc_addr, pf_addr;
  logic          ic_request, dc_request, pf_request;
  logic [LW-1:0] ic_data, dc_data, pf_data;
  logic          ic_done, dc_done, pf_done;
  logic [AW-1:0] l2_addr;
  logic          l2_request;
  logic [LW-1:0] l2_data;
  logic          l2_done;
  logic          busy;
  logic [1:0]    grant_id;

  l2_req_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .OFFSET_BITS(5), .PF_STARVE_LIMIT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_addr(ic_addr), .ic_request(ic_request), .ic_data(ic_data), .ic_done(ic_done),
    .dc_addr(dc_addr), .dc_request(dc_request), .dc_data(dc_data), .dc_done(dc_done),
    .pf_addr(pf_addr), .pf_request(pf_request), .pf_data(pf_data), .pf_done(pf_done),
    .l2_addr(l2_addr), .l2_request(l2_request), .l2_data(l2_data), .l2_done(l2_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic ic_hold, dc_hold, pf_hold;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic set_req(input logic [1:0] id, input logic v);
    case (id)
      ID_IC:   ic_request = v;
      ID_DC:   dc_request = v;
      ID_PF:   pf_request = v;
      default: ;
    endcase
  endtask

  task automatic push(input logic [1:0] id, input logic [AW-1:0] line_addr);
    exp_t e;
    e.id   = id;
    e.addr = line_addr;
    e.data = rand_line();
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      n++;
      if (l2_request === 1'b1) return;
    end
    chk("grant_timeout", 0, 1);
    n = -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_l2_request"}, l2_request, 0);
    chk({tag, "_done"}, {pf_done, dc_done, ic_done}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ic_request = 0; dc_request = 0; pf_request = 0;
    ic_hold = 0; dc_hold = 0; pf_hold = 0;
    l2_done = 0; l2_data = '0;
    step(); step();
    check_idle_outputs("reset");
    chk("reset_l2_addr", l2_addr, 0);
    chk("reset_data", ic_data | dc_data | pf_data, 0);
    reset = 1'b0;
  endtask

  // One complete fill: grant check, WAIT hold, done pulse, return to IDLE
  task automatic serve(input int lat, input bit drop_early, output int n);
    exp_t e;
    logic [2:0]    exp_done;
    logic [LW-1:0] got;
    wait_grant(n);
    if (n < 0) return;
    if (exp_q.size() == 0) begin
      chk("unexpected_grant", grant_id, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("grant_id", grant_id, e.id);
    chk("l2_addr", l2_addr, e.addr);
    chk("busy_wait", busy, 1);
    if (drop_early) begin
      set_req(e.id, 1'b0);
      if (e.id == ID_IC) ic_addr = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_l2_request", l2_request, 1);
      chk("wait_l2_addr", l2_addr, e.addr);
      chk("wait_no_done", {pf_done, dc_done, ic_done}, 0);
    end
    l2_done = 1'b1;
    l2_data = e.data;
    step();
    l2_done = 1'b0;
    l2_data = rand_line();
    exp_done = (e.id == ID_IC) ? 3'b001 : (e.id == ID_DC) ? 3'b010 : 3'b100;
    got = (e.id == ID_IC) ? ic_data : (e.id == ID_DC) ? dc_data : pf_data;
    chk("resp_done", {pf_done, dc_done, ic_done}, exp_done);
    chk("resp_data", got, e.data);
    chk("resp_l2_request", l2_request, 0);
    chk("resp_busy", busy, 1);
    set_req(e.id, 1'b0);
    step();
    check_idle_outputs("after_resp");
    got = (e.id == ID_IC) ? ic_data : (e.id == ID_DC) ? dc_data : pf_data;
    chk("data_holds", got, e.data);
    if ((e.id == ID_IC && ic_hold) || (e.id == ID_DC && dc_hold) || (e.id == ID_PF && pf_hold))
      set_req(e.id, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int   n;
    exp_t e;
    ic_addr = 32'h0000_1234;
    dc_addr = 32'h0000_ABCD;
    pf_addr = 32'h8000_007F;
    do_reset();

    // Single icache fill with fixed latency
    ic_request = 1;
    push(ID_IC, 32'h0000_1220);
    serve(4, 1'b0, n);
    chk("ic_first_latency", n, 1);
    step();
    chk("ic_done_once", ic_done, 0);

    // ic and dc both held: strict alternation starting with ic
    do_reset();
    ic_addr = 32'h0000_1234; dc_addr = 32'h0000_ABCD;
    ic_hold = 1; dc_hold = 1;
    ic_request = 1; dc_request = 1;
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0);
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0);
    push(ID_IC, 32'h0000_1220);
    serve(2, 1'b0, n);
    serve(1, 1'b0, n);
    serve(3, 1'b0, n);
    dc_hold = 0;
    serve(1, 1'b0, n);
    ic_hold = 0;
    serve(2, 1'b0, n);
    chk("rr_queue_drained", exp_q.size(), 0);

    // Starvation guard with a limit of two
    do_reset();
    ic_hold = 1; dc_hold = 1; pf_hold = 1;
    ic_request = 1; dc_request = 1; pf_request = 1;
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0); push(ID_PF, 32'h8000_0060);
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0); push(ID_PF, 32'h8000_0060);
    serve(1, 1'b0, n);
    serve(1, 1'b0, n);
    serve(2, 1'b0, n);
    ic_hold = 0;
    serve(1, 1'b0, n);
    dc_hold = 0;
    serve(1, 1'b0, n);
    pf_hold = 0;
    serve(1, 1'b0, n);
    chk("starve_queue_drained", exp_q.size(), 0);

    // Stray l2_done while idle
    do_reset();
    step();
    l2_done = 1; l2_data = rand_line();
    step();
    l2_done = 0;
    check_idle_outputs("stray");
    chk("stray_data", ic_data | dc_data | pf_data, 0);
    step();
    chk("stray_still_idle", busy, 0);

    // Reset in WAIT coincident with l2_done
    do_reset();
    ic_request = 1; dc_request = 1;
    wait_grant(n);
    chk("pre_reset_grant", grant_id, ID_IC);
    step();
    reset = 1; l2_done = 1; l2_data = rand_line();
    step();
    reset = 0; l2_done = 0;
    check_idle_outputs("mid_reset");
    chk("mid_reset_data", ic_data, 0);
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0);
    serve(3, 1'b0, n);
    chk("post_reset_latency", n, 1);
    serve(1, 1'b0, n);

    // ic drops during WAIT while dc waits; check minimum turnaround
    do_reset();
    ic_addr = 32'h0000_1234;
    ic_request = 1; dc_request = 1;
    push(ID_IC, 32'h0000_1220); push(ID_DC, 32'h0000_ABC0);
    serve(2, 1'b1, n);
    serve(1, 1'b0, n);
    chk("turnaround", n, 1);
    chk("final_queue_drained", exp_q.size(), 0);
    step();
    check_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
